icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Miss-handling controller for the instruction cache that feeds the decode-stage instruction register.
- Holds a direct-mapped tag/valid store and checks PCF against it every cycle.
- On a miss, stalls fetch/decode, fetches the whole line from backing memory over a valid/ready request plus response-beat interface, and writes it into the i_cache data array.
- Services FENCE.I by invalidating all lines.

Parameters:
- DPW, 32, data/PC width (from rv32i_pkg).
- LINE_WORDS, 4, 32-bit words per cache line; power of two, at least 2.
- NUM_LINES, 16, number of lines (direct mapped); power of two.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- PCF  input  DPW  fetch PC; bits [1:0] ignored.
- fence_i  input  1  one-cycle pulse that invalidates all lines.
- hit  output  1  combinational: valid[idx] and tag[idx] equals the PCF tag.
- stallF  output  1  stall request to the fetch and decode stages.
- icache_wr_en  output  1  data-array write strobe.
- icache_wr_addr  output  $clog2(NUM_LINES*LINE_WORDS)  data-array word address, {idx, beat}.
- icache_wr_data  output  DPW  word to write.
- mem_req_valid  output  1  line request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  DPW  line base byte address; word and byte offsets are zero.
- mem_rsp_valid  input  1  response beat valid; beats arrive in word order.
- mem_rsp_data  input  DPW  response word.

Behaviour:
- Address split: byte offset [1:0]; word offset next $clog2(LINE_WORDS) bits; idx next $clog2(NUM_LINES) bits; tag is all remaining bits.
- Reset (async): state IDLE, all valid bits 0, beat counter 0, mem_req_valid 0, icache_wr_en 0, abort flag 0, perf counters 0.
- stallF = (state != IDLE) or (state == IDLE and not hit).
- IDLE:
  - On a miss, latch base address and idx of PCF; go to REQ.
  - fence_i in IDLE clears all valid bits on the next edge, and that cycle's lookup uses the pre-clear valids. If fence_i coincides with a miss, the refill still starts.
- REQ:
  - mem_req_valid = 1, mem_req_addr = latched base.
  - valid must hold until mem_req_ready; the address is stable while waiting.
  - On ready, go to FILL with beat = 0.
- FILL:
  - Each mem_rsp_valid cycle: icache_wr_en = 1, wr_addr = {idx, beat}, wr_data = mem_rsp_data, beat increments.
  - After beat LINE_WORDS-1 is written, go to DONE. The beat counter wraps to 0.
- DONE (one cycle): write tag[idx] = latched tag and valid[idx] = 1, unless the abort flag is set. Clear the abort flag and go to IDLE.
- fence_i outside IDLE:
  - Clears all valid bits immediately and sets the abort flag.
  - The in-flight refill runs to completion (the request is never withdrawn, all beats are consumed), but the line is not validated.
- PCF changes (redirect/flush) during a refill do not abort it. The line is validated for the latched address; after returning to IDLE, the new PCF is looked up.
- mem_rsp_valid outside FILL is ignored (covered by a simulation assertion).
- Only one request is outstanding at a time.
- Miss penalty with zero-wait memory (ready=1, responses starting the cycle after acceptance, one per cycle):
  - miss at cycle 0
  - REQ at cycle 1
  - FILL at cycles 2..5
  - DONE at cycle 6
  - hit, stallF = 0 at cycle 7
- Reset mid-refill: state returns to IDLE and valids clear. Any later stray beats are ignored.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- When defined:
  - Adds outputs hit_cnt and miss_cnt, each 32-bit.
  - hit_cnt increments on IDLE cycles with hit = 1.
  - miss_cnt increments on each IDLE-to-REQ transition.
  - Both saturate at all-ones and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- rv32i_pkg gets:
  - LINE_WORDS and NUM_LINES defaults.
  - Derived widths: IDX_W, OFF_W, TAG_W.
  - Typedef icache_state_e {IDLE, REQ, FILL, DONE}.
- Sub-module icache_tag_store holds the tag/valid arrays and exposes:
  - Combinational lookup.
  - A single write port.
  - Flash invalidate.
- The FSM, beat counter and memory interface stay in icache_refill_ctrl.

Test Plan:
- Cold miss at PCF=0x0000_0040, zero-wait memory returning 0xA0..0xA3:
  - stallF high for cycles 0..6.
  - Writes at wr_addr 16..19 with data 0xA0..0xA3.
  - mem_req_addr = 0x40.
  - hit = 1 at cycle 7.
- mem_req_ready held low for 5 cycles:
  - mem_req_valid and mem_req_addr stay stable throughout.
  - Exactly one handshake occurs.
- Gapped responses (one beat every 3 cycles) → wr_addr increments only on mem_rsp_valid; DONE follows the 4th beat.
- fence_i during the FILL of 0x80:
  - All 4 beats are still written.
  - After return to IDLE, a 0x80 lookup misses and a new request is issued.
  - A previously valid line at 0x40 also misses.
- Conflict: fill 0x040, then 0x440 (same idx, different tag) → the second fill replaces the tag; 0x040 then misses.
- With ICACHE_PERF_CNT_EN: 1 miss then 10 hit cycles → miss_cnt = 1, hit_cnt = 10; rst mid-FILL clears both counters and returns the state to IDLE.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I core constants plus the instruction-cache geometry defaults,
// derived address-field widths and refill FSM state encoding.
package rv32i_pkg;

  localparam int DPW               = 32;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_NUM_LINES  = 16;

  localparam int OFF_W = $clog2(ICACHE_LINE_WORDS);
  localparam int IDX_W = $clog2(ICACHE_NUM_LINES);
  localparam int TAG_W = DPW - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } icache_state_e;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Backing-memory line request (valid/ready) and response-beat bus used by
// the instruction-cache refill controller.
interface icache_refill_ctrl_if #(
  parameter int DPW = 32
);

  logic           mem_req_valid;
  logic           mem_req_ready;
  logic [DPW-1:0] mem_req_addr;
  logic           mem_rsp_valid;
  logic [DPW-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );

endinterface

// File: rtl/icache_tag_store.sv
// Direct-mapped tag/valid store: combinational lookup, one write port and a
// flash invalidate that takes priority over a same-cycle write.
module icache_tag_store #(
  parameter int IDX_BITS = rv32i_pkg::IDX_W,
  parameter int TAG_BITS = rv32i_pkg::TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  input  logic [TAG_BITS-1:0] i_rd_tag,
  output logic                o_hit,
  input  logic                i_wr_en,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic [TAG_BITS-1:0] i_wr_tag,
  input  logic                i_flash_inv
);

  localparam int N_LINES = 1 << IDX_BITS;

  logic [N_LINES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag [N_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_flash_inv) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // NOTE: the tag array is deliberately not reset; every read is qualified by r_valid.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  assign o_hit = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: looks up PCF, stalls fetch/decode on a miss
// and refills the whole line beat by beat. Optional counters: ICACHE_PERF_CNT_EN.
module icache_refill_ctrl
  import rv32i_pkg::*;
#(
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [DPW-1:0]                          PCF,
  input  logic                                    fence_i,
  output logic                                    hit,
  output logic                                    stallF,
  output logic                                    icache_wr_en,
  output logic [$clog2(NUM_LINES*LINE_WORDS)-1:0] icache_wr_addr,
  output logic [DPW-1:0]                          icache_wr_data,
  icache_refill_ctrl_if.master                    mem
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                             hit_cnt,
  output logic [31:0]                             miss_cnt
`endif
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int LO       = OFF_BITS + 2;
  localparam int TAG_BITS = DPW - IDX_BITS - LO;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_FILL = FILL;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]          r_state;
  logic [OFF_BITS-1:0] r_beat;
  logic [DPW-1:0]      r_base;
  logic                r_abort;

  logic [IDX_BITS-1:0] w_pc_idx;
  logic [TAG_BITS-1:0] w_pc_tag;
  logic [IDX_BITS-1:0] w_base_idx;
  logic [TAG_BITS-1:0] w_base_tag;
  logic                w_last_beat;
  logic                w_tag_wr_en;
  logic                w_unused_pc_bits;

  assign w_pc_idx         = PCF[LO +: IDX_BITS];
  assign w_pc_tag         = PCF[DPW-1 -: TAG_BITS];
  assign w_base_idx       = r_base[LO +: IDX_BITS];
  assign w_base_tag       = r_base[DPW-1 -: TAG_BITS];
  assign w_last_beat      = (r_beat == OFF_BITS'(LINE_WORDS - 1));
  assign w_unused_pc_bits = ^PCF[LO-1:0];

  // A fence landing in DONE must also keep the just-filled line invalid.
  assign w_tag_wr_en = (r_state == ST_DONE) && !r_abort && !fence_i;

  icache_tag_store #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_tag_store (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (w_pc_idx),
    .i_rd_tag    (w_pc_tag),
    .o_hit       (hit),
    .i_wr_en     (w_tag_wr_en),
    .i_wr_idx    (w_base_idx),
    .i_wr_tag    (w_base_tag),
    .i_flash_inv (fence_i)
  );

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_base  <= '0;
      r_abort <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!hit) begin
            r_base  <= {PCF[DPW-1:LO], {LO{1'b0}}};
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem.mem_req_ready) begin
            r_beat  <= '0;
            r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem.mem_rsp_valid) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // Cleared in DONE so a fence there cannot leak into the next refill.
      if (r_state == ST_DONE) begin
        r_abort <= 1'b0;
      end else if (fence_i && (r_state != ST_IDLE)) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign stallF            = (r_state != ST_IDLE) || !hit;
  assign mem.mem_req_valid = (r_state == ST_REQ);
  assign mem.mem_req_addr  = r_base;
  assign icache_wr_en      = (r_state == ST_FILL) && mem.mem_rsp_valid;
  assign icache_wr_addr    = {w_base_idx, r_beat};
  assign icache_wr_data    = mem.mem_rsp_data;

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (!hit && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

  a_rsp_outside_fill_ignored: assert property (
    @(posedge clk) disable iff (rst)
    (mem.mem_rsp_valid && (r_state != ST_FILL)) |-> !icache_wr_en
  );

  a_req_held_until_ready: assert property (
    @(posedge clk) disable iff (rst)
    (mem.mem_req_valid && !mem.mem_req_ready) |=> (mem.mem_req_valid && $stable(mem.mem_req_addr))
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: behavioural backing memory, write
// monitor and one task per scenario. Counter checks need ICACHE_PERF_CNT_EN.
module tb_icache_refill_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        fence_i;
  logic        hit;
  logic        stallF;
  logic        icache_wr_en;
  logic [5:0]  icache_wr_addr;
  logic [31:0] icache_wr_data;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_refill_ctrl_if #(.DPW(32)) mem_bus ();

  icache_refill_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .PCF            (PCF),
    .fence_i        (fence_i),
    .hit            (hit),
    .stallF         (stallF),
    .icache_wr_en   (icache_wr_en),
    .icache_wr_addr (icache_wr_addr),
    .icache_wr_data (icache_wr_data),
    .mem            (mem_bus.master)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // memory model configuration (written only by the test sequence)
  int          ready_delay = 0;
  int          beat_gap    = 0;
  logic [31:0] data_base   = 32'hA0;
  bit          hold_req    = 1'b0;
  int          stray_total = 0;

  // monitor results
  logic [5:0]  log_addr [$];
  logic [31:0] log_data [$];
  int          hs_cnt  = 0;
  logic [31:0] hs_addr = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // Behavioural backing memory: ready after ready_delay cycles, then 4 beats
  // separated by beat_gap idle cycles; a reset abandons the burst.
  initial begin
    int strays_done;
    strays_done = 0;
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (strays_done < stray_total) begin
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = 32'hDEAD_0000 + 32'(strays_done);
        strays_done++;
      end else begin
        mem_bus.mem_rsp_valid = 1'b0;
        if (mem_bus.mem_req_valid && !hold_req) begin
          repeat (ready_delay) @(negedge clk);
          mem_bus.mem_req_ready = 1'b1;
          @(negedge clk);
          mem_bus.mem_req_ready = 1'b0;
          for (int k = 0; k < 4; k++) begin
            repeat (beat_gap) @(negedge clk);
            mem_bus.mem_rsp_valid = 1'b1;
            mem_bus.mem_rsp_data  = data_base + 32'(k);
            @(negedge clk);
            mem_bus.mem_rsp_valid = 1'b0;
            if (rst) break;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && icache_wr_en) begin
        log_addr.push_back(icache_wr_addr);
        log_data.push_back(icache_wr_data);
      end
      if (!rst && mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
        hs_cnt++;
        hs_addr = mem_bus.mem_req_addr;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!stallF) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_wr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (icache_wr_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_total++;
    if (stallF !== 1'b1) $display("FAIL reset_stallF: got %b want 1", stallF); else n_pass++;
    n_total++;
    if (hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", hit); else n_pass++;
    n_total++;
    if (mem_bus.mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", mem_bus.mem_req_valid); else n_pass++;
    n_total++;
    if (icache_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", icache_wr_en); else n_pass++;
  endtask

  task automatic test_cold_miss();
    int hs0;
    hs0 = hs_cnt;
    clear_log();
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) tick();
      n_total++;
      if (stallF !== (c <= 6)) $display("FAIL cold_stallF_c%0d: got %b want %b", c, stallF, (c <= 6)); else n_pass++;
      n_total++;
      if (mem_bus.mem_req_valid !== (c == 1)) $display("FAIL cold_req_valid_c%0d: got %b want %b", c, mem_bus.mem_req_valid, (c == 1)); else n_pass++;
      n_total++;
      if (icache_wr_en !== (c >= 2 && c <= 5)) $display("FAIL cold_wr_en_c%0d: got %b want %b", c, icache_wr_en, (c >= 2 && c <= 5)); else n_pass++;
    end
    n_total++;
    if (hit !== 1'b1) $display("FAIL cold_hit_c7: got %b want 1", hit); else n_pass++;
    tick();
    n_total++;
    if (log_addr.size() != 4) $display("FAIL cold_wr_count: got %0d want 4", log_addr.size()); else n_pass++;
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      n_total++;
      if (log_addr[k] !== 6'(16 + k) || log_data[k] !== 32'hA0 + 32'(k))
        $display("FAIL cold_wr%0d: got addr %0d data %h want addr %0d data %h", k, log_addr[k], log_data[k], 16 + k, 32'hA0 + 32'(k));
      else n_pass++;
    end
    n_total++;
    if (hs_cnt - hs0 != 1) $display("FAIL cold_handshakes: got %0d want 1", hs_cnt - hs0); else n_pass++;
    n_total++;
    if (hs_addr !== 32'h40) $display("FAIL cold_req_addr: got %h want 00000040", hs_addr); else n_pass++;
  endtask

  task automatic test_ready_stall();
    int hs0;
    bit found;
    bit ok;
    hs0 = hs_cnt;
    ready_delay = 5;
    data_base = 32'hF0;
    PCF = 32'h0C0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_bus.mem_req_valid) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (!found) $display("FAIL stall_req_seen: got no request want one"); else n_pass++;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      n_total++;
      if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_addr !== 32'h0C0)
        $display("FAIL stall_hold_k%0d: got valid %b addr %h want valid 1 addr 000000c0", k, mem_bus.mem_req_valid, mem_bus.mem_req_addr);
      else n_pass++;
    end
    wait_idle(ok);
    n_total++;
    if (!ok) $display("FAIL stall_idle_timeout: got stall want idle"); else n_pass++;
    n_total++;
    if (hs_cnt - hs0 != 1) $display("FAIL stall_handshakes: got %0d want 1", hs_cnt - hs0); else n_pass++;
    n_total++;
    if (hit !== 1'b1) $display("FAIL stall_hit: got %b want 1", hit); else n_pass++;
    ready_delay = 0;
  endtask

  task automatic test_gapped();
    int w_cyc [4];
    int nw;
    int idle_c;
    beat_gap = 2;
    data_base = 32'hB0;
    clear_log();
    PCF = 32'h100;
    nw = 0;
    idle_c = -1;
    for (int c = 1; c < 80; c++) begin
      tick();
      if (icache_wr_en) begin
        if (nw < 4) w_cyc[nw] = c;
        nw++;
      end
      if (!stallF) begin
        idle_c = c;
        break;
      end
    end
    n_total++;
    if (nw != 4) $display("FAIL gap_wr_cycles: got %0d want 4", nw); else n_pass++;
    for (int k = 1; k < 4 && k < nw; k++) begin
      n_total++;
      if (w_cyc[k] - w_cyc[k-1] != 3) $display("FAIL gap_spacing%0d: got %0d want 3", k, w_cyc[k] - w_cyc[k-1]); else n_pass++;
    end
    if (nw >= 4) begin
      n_total++;
      if (idle_c != w_cyc[3] + 2) $display("FAIL gap_done_timing: got idle at %0d want %0d", idle_c, w_cyc[3] + 2); else n_pass++;
    end
    tick();
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      n_total++;
      if (log_addr[k] !== 6'(k) || log_data[k] !== 32'hB0 + 32'(k))
        $display("FAIL gap_wr%0d: got addr %0d data %h want addr %0d data %h", k, log_addr[k], log_data[k], k, 32'hB0 + 32'(k));
      else n_pass++;
    end
    beat_gap = 0;
  endtask

  task automatic test_fence();
    int nw;
    bit ok;
    data_base = 32'hC0;
    clear_log();
    PCF = 32'h080;
    nw = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      fence_i = 1'b0;
      if (icache_wr_en) begin
        nw++;
        if (nw == 1) fence_i = 1'b1;
      end
      if (nw == 4) break;
    end
    fence_i = 1'b0;
    n_total++;
    if (nw != 4) $display("FAIL fence_beats: got %0d want 4", nw); else n_pass++;
    tick();
    n_total++;
    if (stallF !== 1'b1 || mem_bus.mem_req_valid !== 1'b0) $display("FAIL fence_done: got stall %b req %b want 1 0", stallF, mem_bus.mem_req_valid); else n_pass++;
    tick();
    n_total++;
    if (hit !== 1'b0 || mem_bus.mem_req_valid !== 1'b0) $display("FAIL fence_idle_miss: got hit %b req %b want 0 0", hit, mem_bus.mem_req_valid); else n_pass++;
    tick();
    n_total++;
    if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_addr !== 32'h080)
      $display("FAIL fence_rerequest: got valid %b addr %h want 1 00000080", mem_bus.mem_req_valid, mem_bus.mem_req_addr);
    else n_pass++;
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      n_total++;
      if (log_addr[k] !== 6'(32 + k) || log_data[k] !== 32'hC0 + 32'(k))
        $display("FAIL fence_wr%0d: got addr %0d data %h want addr %0d data %h", k, log_addr[k], log_data[k], 32 + k, 32'hC0 + 32'(k));
      else n_pass++;
    end
    wait_idle(ok);
    n_total++;
    if (!ok || hit !== 1'b1) $display("FAIL fence_refill_hit: got ok %b hit %b want 1 1", ok, hit); else n_pass++;
    PCF = 32'h040;
    #1;
    n_total++;
    if (hit !== 1'b0) $display("FAIL fence_old_line: got hit %b want 0", hit); else n_pass++;
    wait_idle(ok);
    n_total++;
    if (!ok || hit !== 1'b1) $display("FAIL fence_40_refill: got ok %b hit %b want 1 1", ok, hit); else n_pass++;
  endtask

  task automatic test_conflict();
    bit ok;
    data_base = 32'hD0;
    clear_log();
    PCF = 32'h440;
    wait_idle(ok);
    n_total++;
    if (!ok || hit !== 1'b1) $display("FAIL conflict_fill: got ok %b hit %b want 1 1", ok, hit); else n_pass++;
    n_total++;
    if (log_addr.size() != 4) $display("FAIL conflict_wr_count: got %0d want 4", log_addr.size()); else n_pass++;
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      n_total++;
      if (log_addr[k] !== 6'(16 + k) || log_data[k] !== 32'hD0 + 32'(k))
        $display("FAIL conflict_wr%0d: got addr %0d data %h want addr %0d data %h", k, log_addr[k], log_data[k], 16 + k, 32'hD0 + 32'(k));
      else n_pass++;
    end
    PCF = 32'h040;
    #1;
    n_total++;
    if (hit !== 1'b0 || stallF !== 1'b1) $display("FAIL conflict_evicted: got hit %b stall %b want 0 1", hit, stallF); else n_pass++;
    wait_idle(ok);
    n_total++;
    if (!ok || hit !== 1'b1) $display("FAIL conflict_refill: got ok %b hit %b want 1 1", ok, hit); else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    data_base = 32'hE0;
    PCF = 32'h200;
    wait_wr(ok);
    n_total++;
    if (!ok) $display("FAIL rstfill_no_beat: got none want a fill beat"); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (mem_bus.mem_req_valid !== 1'b0 || icache_wr_en !== 1'b0)
      $display("FAIL rstfill_outputs: got req %b wr %b want 0 0", mem_bus.mem_req_valid, icache_wr_en);
    else n_pass++;
    PCF = 32'h040;
    #1;
    n_total++;
    if (hit !== 1'b0) $display("FAIL rstfill_valids: got hit %b want 0", hit); else n_pass++;
    tick();
    hold_req = 1'b1;
    stray_total = stray_total + 3;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (icache_wr_en !== 1'b0 || mem_bus.mem_req_valid !== 1'b0)
      $display("FAIL rstfill_idle_stray: got wr %b req %b want 0 0", icache_wr_en, mem_bus.mem_req_valid);
    else n_pass++;
    tick();
    n_total++;
    if (icache_wr_en !== 1'b0 || mem_bus.mem_req_valid !== 1'b1)
      $display("FAIL rstfill_req_stray: got wr %b req %b want 0 1", icache_wr_en, mem_bus.mem_req_valid);
    else n_pass++;
    tick();
    n_total++;
    if (icache_wr_en !== 1'b0) $display("FAIL rstfill_req_stray2: got wr %b want 0", icache_wr_en); else n_pass++;
    clear_log();
    hold_req = 1'b0;
    wait_idle(ok);
    n_total++;
    if (!ok || hit !== 1'b1) $display("FAIL rstfill_refill: got ok %b hit %b want 1 1", ok, hit); else n_pass++;
    n_total++;
    if (log_addr.size() != 4) $display("FAIL rstfill_wr_count: got %0d want 4", log_addr.size()); else n_pass++;
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      n_total++;
      if (log_addr[k] !== 6'(16 + k) || log_data[k] !== 32'hE0 + 32'(k))
        $display("FAIL rstfill_wr%0d: got addr %0d data %h want addr %0d data %h", k, log_addr[k], log_data[k], 16 + k, 32'hE0 + 32'(k));
      else n_pass++;
    end
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_cnt();
    bit ok;
    tick();
    rst = 1'b1;
    #1;
    n_total++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) $display("FAIL perf_reset: got hit %0d miss %0d want 0 0", hit_cnt, miss_cnt); else n_pass++;
    PCF = 32'h040;
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    wait_idle(ok);
    n_total++;
    if (!ok || miss_cnt !== 32'd1 || hit_cnt !== 32'd0)
      $display("FAIL perf_after_miss: got ok %b hit %0d miss %0d want 1 0 1", ok, hit_cnt, miss_cnt);
    else n_pass++;
    repeat (10) tick();
    n_total++;
    if (hit_cnt !== 32'd10 || miss_cnt !== 32'd1) $display("FAIL perf_hits: got hit %0d miss %0d want 10 1", hit_cnt, miss_cnt); else n_pass++;
    PCF = 32'h080;
    wait_wr(ok);
    n_total++;
    if (!ok || hit_cnt !== 32'd10 || miss_cnt !== 32'd2)
      $display("FAIL perf_second_miss: got ok %b hit %0d miss %0d want 1 10 2", ok, hit_cnt, miss_cnt);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0 || mem_bus.mem_req_valid !== 1'b0)
      $display("FAIL perf_rst_mid_fill: got hit %0d miss %0d req %b want 0 0 0", hit_cnt, miss_cnt, mem_bus.mem_req_valid);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    PCF = 32'h040;
    fence_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_cold_miss();
    test_ready_stall();
    test_gapped();
    test_fence();
    test_conflict();
    test_reset_mid_fill();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
